// File: rtl/maze_env.sv
// rtl/maze_env.sv - walled 8x8 grid environment: robot pose, wall sensors, move counter
// Consumes front/rotate commands and presents Moore-style head/left wall sensors.
module maze_env #(
  parameter logic [63:0] MAP       = 64'h0,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 0,
  parameter int unsigned START_DIR = 0,
  parameter int unsigned GOAL_X    = 7,
  parameter int unsigned GOAL_Y    = 7,
  parameter int unsigned MOVES_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               front,
  input  logic               rotate,
  output logic               head,
  output logic               left,
  output logic [2:0]         pos_x,
  output logic [2:0]         pos_y,
  output logic [1:0]         dir,
  output logic               collision,
  output logic               at_goal,
  output logic [MOVES_W-1:0] moves
);

  localparam logic [2:0] SX = 3'(START_X);
  localparam logic [2:0] SY = 3'(START_Y);
  localparam logic [1:0] SD = 2'(START_DIR);
  localparam logic [2:0] GX = 3'(GOAL_X);
  localparam logic [2:0] GY = 3'(GOAL_Y);

  logic [2:0]         x_q, x_d, y_q, y_d;
  logic [1:0]         dir_q, dir_d;
  logic               coll_q, coll_d;
  logic [MOVES_W-1:0] moves_q, moves_d;
  logic [5:0]         fwd_cell;

  // Returns {ny, nx}; the 3-bit wrap is harmless because at_edge masks it.
  function automatic logic [5:0] neighbour(input logic [2:0] x, input logic [2:0] y,
                                           input logic [1:0] d);
    logic [2:0] nx;
    logic [2:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'd0:    ny = y - 3'd1;
      2'd1:    nx = x + 3'd1;
      2'd2:    ny = y + 3'd1;
      default: nx = x - 3'd1;
    endcase
    return {ny, nx};
  endfunction

  function automatic logic at_edge(input logic [2:0] x, input logic [2:0] y,
                                   input logic [1:0] d);
    case (d)
      2'd0:    return y == 3'd0;
      2'd1:    return x == 3'd7;
      2'd2:    return y == 3'd7;
      default: return x == 3'd0;
    endcase
  endfunction

  function automatic logic blocked(input logic [2:0] x, input logic [2:0] y,
                                   input logic [1:0] d);
    return at_edge(x, y, d) | MAP[neighbour(x, y, d)];
  endfunction

  assign fwd_cell = neighbour(x_q, y_q, dir_q);
  assign head     = blocked(x_q, y_q, dir_q);
  assign left     = blocked(x_q, y_q, dir_q + 2'd3);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    coll_d  = coll_q;
    moves_d = moves_q;
    if (rotate) begin
      dir_d = dir_q + 2'd1;
    end else if (front && !head) begin
      x_d = fwd_cell[2:0];
      y_d = fwd_cell[5:3];
      if (moves_q != '1) moves_d = moves_q + 1'b1;
    end else if (front) begin
      coll_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= SX;
      y_q     <= SY;
      dir_q   <= SD;
      coll_q  <= 1'b0;
      moves_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      coll_q  <= coll_d;
      moves_q <= moves_d;
    end
  end

  assign pos_x     = x_q;
  assign pos_y     = y_q;
  assign dir       = dir_q;
  assign collision = coll_q;
  assign moves     = moves_q;
  assign at_goal   = (x_q == GX) && (y_q == GY);

endmodule

// File: tb/tb_maze_env.sv
// tb/tb_maze_env.sv - scoreboard bench for maze_env with a grid-walk reference model
// Three instances with different maps/starts share one command stream.
module tb_maze_env;

  localparam logic [63:0] MAP1 = 64'h0081_4200_1000_0200;
  localparam logic [63:0] MAP2 = 64'hA5A5_0000_0C41_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic front = 1'b0;
  logic rotate = 1'b0;

  always #5 clk = ~clk;

  logic       head0, left0, coll0, goal0;
  logic [2:0] x0, y0;
  logic [1:0] d0;
  logic [15:0] mv0;
  logic       head1, left1, coll1, goal1;
  logic [2:0] x1, y1;
  logic [1:0] d1;
  logic [2:0] mv1;
  logic       head2, left2, coll2, goal2;
  logic [2:0] x2, y2;
  logic [1:0] d2;
  logic [3:0] mv2;

  maze_env #(.MAP(64'h0), .START_X(0), .START_Y(0), .START_DIR(0),
             .GOAL_X(7), .GOAL_Y(7), .MOVES_W(16)) u_env0 (
    .clk(clk), .rst(rst), .front(front), .rotate(rotate), .head(head0), .left(left0),
    .pos_x(x0), .pos_y(y0), .dir(d0), .collision(coll0), .at_goal(goal0), .moves(mv0));

  maze_env #(.MAP(MAP1), .START_X(1), .START_Y(0), .START_DIR(2),
             .GOAL_X(7), .GOAL_Y(7), .MOVES_W(3)) u_env1 (
    .clk(clk), .rst(rst), .front(front), .rotate(rotate), .head(head1), .left(left1),
    .pos_x(x1), .pos_y(y1), .dir(d1), .collision(coll1), .at_goal(goal1), .moves(mv1));

  maze_env #(.MAP(MAP2), .START_X(2), .START_Y(3), .START_DIR(3),
             .GOAL_X(2), .GOAL_Y(3), .MOVES_W(4)) u_env2 (
    .clk(clk), .rst(rst), .front(front), .rotate(rotate), .head(head2), .left(left2),
    .pos_x(x2), .pos_y(y2), .dir(d2), .collision(coll2), .at_goal(goal2), .moves(mv2));

  // Reference parameters and state, one slot per instance.
  logic [63:0] pmap[3] = '{64'h0, MAP1, MAP2};
  int sx[3] = '{0, 1, 2};
  int sy[3] = '{0, 0, 3};
  int sd[3] = '{0, 2, 3};
  int gx[3] = '{7, 7, 2};
  int gy[3] = '{7, 7, 3};
  int mw[3] = '{16, 3, 4};
  int dxt[4] = '{0, 1, 0, -1};
  int dyt[4] = '{-1, 0, 1, 0};
  int mx[3], my[3], md[3], mc[3], mm[3];

  typedef logic [2:0][27:0] exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic bit m_blocked(int k, int x, int y, int d);
    int nx = x + dxt[d];
    int ny = y + dyt[d];
    if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return 1'b1;
    return pmap[k][ny*8 + nx];
  endfunction

  function automatic logic [27:0] m_outputs(int k);
    logic [27:0] v;
    v = {m_blocked(k, mx[k], my[k], md[k]), m_blocked(k, mx[k], my[k], (md[k] + 3) % 4),
         3'(mx[k]), 3'(my[k]), 2'(md[k]), 1'(mc[k]),
         1'(mx[k] == gx[k] && my[k] == gy[k]), 16'(mm[k])};
    return v;
  endfunction

  task automatic m_step(input bit r, input bit f, input bit ro);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mx[k] = sx[k]; my[k] = sy[k]; md[k] = sd[k]; mc[k] = 0; mm[k] = 0;
      end else if (ro) begin
        md[k] = (md[k] + 1) % 4;
      end else if (f) begin
        if (m_blocked(k, mx[k], my[k], md[k])) begin
          mc[k] = 1;
        end else begin
          mx[k] += dxt[md[k]];
          my[k] += dyt[md[k]];
          if (mm[k] < (1 << mw[k]) - 1) mm[k]++;
        end
      end
      e[k] = m_outputs(k);
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit f, input bit ro);
    @(negedge clk);
    rst = r;
    front = f;
    rotate = ro;
    m_step(r, f, ro);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0][27:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got[0] = {head0, left0, x0, y0, d0, coll0, goal0, mv0};
        got[1] = {head1, left1, x1, y1, d1, coll1, goal1, 13'd0, mv1};
        got[2] = {head2, left2, x2, y2, d2, coll2, goal2, 12'd0, mv2};
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (got[k] !== e[k]) begin
            miscompares++;
            $display("FAIL env%0d {head,left,x,y,dir,coll,goal,moves} got=%h exp=%h t=%0t",
                     k, got[k], e[k], $time);
          end
        end
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    cyc(1, 0, 0);
    cyc(1, 1, 1);
    // Rotate east, run to the east wall, then bump it.
    cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, f, ro;
      r  = ($urandom_range(0, 79) == 0);
      ro = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) < 7);
      cyc(r, f, ro);
    end
    cyc(0, 0, 0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
